// File: rtl/rx_uart_cfg_if.sv
// Received-word handshake between the UART receiver and its consumer.
// The producer drives the word and its status flags; the consumer drives in_ready.
interface rx_uart_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] out_data;
    logic                 out_valid;
    logic                 in_ready;
    logic                 out_parity_err;
    logic                 out_frame_err;
    logic                 out_overrun;
    logic                 out_busy;

    modport master (
        output out_data, out_valid, out_parity_err, out_frame_err, out_overrun, out_busy,
        input  in_ready
    );

    modport slave (
        input  out_data, out_valid, out_parity_err, out_frame_err, out_overrun, out_busy,
        output in_ready
    );
endinterface

// File: rtl/rx_uart_cfg.sv
// Configurable UART receiver: runtime divisor, optional parity, 1/2 stop bits,
// start-glitch rejection and a valid/ready output with per-frame status.
module rx_uart_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int TIMER_BITS = 16
) (
    input  logic                  clk,
    input  logic                  i_reset_n,
    input  logic                  uart_txd_in,
    input  logic [TIMER_BITS-1:0] in_baud_div,
    rx_uart_cfg_if.master         rx
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    logic                  sync1_reg;
    logic                  rx_s;
    logic                  prev_reg;

    state_t                state_reg;
    logic [TIMER_BITS-1:0] cnt_reg;
    logic [TIMER_BITS-1:0] div_reg;
    logic [3:0]            idx_reg;
    logic [DATA_BITS-1:0]  shift_reg;
    logic                  perr_reg;
    logic                  ferr_reg;
    logic                  done_reg;

    logic [DATA_BITS-1:0]  data_reg;
    logic                  valid_reg;
    logic                  operr_reg;
    logic                  oferr_reg;
    logic                  ovr_reg;
    logic                  busy_reg;

    logic [TIMER_BITS-1:0] div_clamped;
    logic                  tick;
    logic                  fall;

    assign div_clamped = (in_baud_div < TIMER_BITS'(4)) ? TIMER_BITS'(4) : in_baud_div;
    assign tick        = (cnt_reg == '0);
    assign fall        = prev_reg && !rx_s;

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_reg <= 1'b1;
            rx_s      <= 1'b1;
            prev_reg  <= 1'b1;
        end else begin
            sync1_reg <= uart_txd_in;
            rx_s      <= sync1_reg;
            prev_reg  <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            div_reg   <= '0;
            idx_reg   <= '0;
            shift_reg <= '0;
            perr_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
            done_reg  <= 1'b0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            operr_reg <= 1'b0;
            oferr_reg <= 1'b0;
            ovr_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            ovr_reg  <= 1'b0;
            if (state_reg != ST_IDLE) begin
                cnt_reg <= tick ? (div_reg - 1'b1) : (cnt_reg - 1'b1);
            end

            case (state_reg)
                ST_IDLE: begin
                    // Divisor is latched here so mid-frame port changes are ignored.
                    if (fall) begin
                        div_reg   <= div_clamped;
                        cnt_reg   <= (div_clamped >> 1) - 1'b1;
                        state_reg <= ST_START;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (rx_s) begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            idx_reg   <= '0;
                            perr_reg  <= 1'b0;
                            ferr_reg  <= 1'b0;
                            state_reg <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (idx_reg == 4'(DATA_BITS - 1)) begin
                            idx_reg   <= '0;
                            state_reg <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        perr_reg  <= ((^shift_reg) ^ rx_s) != (PARITY == 1);
                        state_reg <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Leave right after the last stop sample so a following start edge is caught.
                    if (tick) begin
                        if (!rx_s) begin
                            ferr_reg <= 1'b1;
                        end
                        if (idx_reg == 4'(STOP_BITS - 1)) begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase

            if (done_reg) begin
                if (!valid_reg || rx.in_ready) begin
                    data_reg  <= shift_reg;
                    operr_reg <= perr_reg;
                    oferr_reg <= ferr_reg;
                    valid_reg <= 1'b1;
                end else begin
                    ovr_reg <= 1'b1;
                end
            end else if (valid_reg && rx.in_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign rx.out_data       = data_reg;
    assign rx.out_valid      = valid_reg;
    assign rx.out_parity_err = operr_reg;
    assign rx.out_frame_err  = oferr_reg;
    assign rx.out_overrun    = ovr_reg;
    assign rx.out_busy       = busy_reg;
endmodule

// File: tb/tb_rx_uart_cfg.sv
// Scoreboard bench for rx_uart_cfg: three receiver configurations, each with its
// own serial line, expected-word queue and handshake monitor.
module tb_rx_uart_cfg;
    typedef struct {
        logic [8:0] data;
        logic       pe;
        logic       fe;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        line0 = 1'b1;
    logic        line1 = 1'b1;
    logic        line2 = 1'b1;
    logic [15:0] div0 = 16'd16;
    logic [15:0] div12 = 16'd16;

    int checks = 0;
    int errors = 0;
    int ovr_cycles0 = 0;
    exp_t exp_q0[$];
    exp_t exp_q1[$];
    exp_t exp_q2[$];

    rx_uart_cfg_if #(.DATA_BITS(8)) if0 ();
    rx_uart_cfg_if #(.DATA_BITS(7)) if1 ();
    rx_uart_cfg_if #(.DATA_BITS(8)) if2 ();

    rx_uart_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .TIMER_BITS(16)) dut0 (
        .clk(clk), .i_reset_n(rst_n), .uart_txd_in(line0), .in_baud_div(div0), .rx(if0.master));
    rx_uart_cfg #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .TIMER_BITS(16)) dut1 (
        .clk(clk), .i_reset_n(rst_n), .uart_txd_in(line1), .in_baud_div(div12), .rx(if1.master));
    rx_uart_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .TIMER_BITS(16)) dut2 (
        .clk(clk), .i_reset_n(rst_n), .uart_txd_in(line2), .in_baud_div(div12), .rx(if2.master));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_word(input string name, input exp_t e, input logic [8:0] d,
                                input logic pe, input logic fe);
        $display("%s word data=%h perr=%b ferr=%b (exp %h %b %b)", name, d, pe, fe, e.data, e.pe, e.fe);
        chk(name, {5'd0, fe, pe, d}, {5'd0, e.fe, e.pe, e.data});
    endtask

    task automatic unexpected(input string name, input logic [8:0] d);
        checks++;
        errors++;
        $display("FAIL %s unexpected word: got %h expected none", name, d);
    endtask

    // Monitors: one pop per accepted handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (if0.out_valid && if0.in_ready) begin
                if (exp_q0.size() == 0) unexpected("dut0", {1'b0, if0.out_data});
                else compare_word("dut0", exp_q0.pop_front(), {1'b0, if0.out_data},
                                  if0.out_parity_err, if0.out_frame_err);
            end
            if (if0.out_overrun) ovr_cycles0++;
            if (if1.out_valid && if1.in_ready) begin
                if (exp_q1.size() == 0) unexpected("dut1", {2'b0, if1.out_data});
                else compare_word("dut1", exp_q1.pop_front(), {2'b0, if1.out_data},
                                  if1.out_parity_err, if1.out_frame_err);
            end
            if (if2.out_valid && if2.in_ready) begin
                if (exp_q2.size() == 0) unexpected("dut2", {1'b0, if2.out_data});
                else compare_word("dut2", exp_q2.pop_front(), {1'b0, if2.out_data},
                                  if2.out_parity_err, if2.out_frame_err);
            end
        end
    end

    // bits[0] is the start bit; caller is aligned to posedge+1.
    task automatic send(input int which, input logic [15:0] bits, input int n, input int div);
        for (int i = 0; i < n; i++) begin
            case (which)
                0:       line0 = bits[i];
                1:       line1 = bits[i];
                default: line2 = bits[i];
            endcase
            repeat (div) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        if0.in_ready = 1'b1;
        if1.in_ready = 1'b1;
        if2.in_ready = 1'b1;

        #2;
        chk("reset valid", {15'd0, if0.out_valid}, 16'd0);
        chk("reset data", {8'd0, if0.out_data}, 16'd0);
        chk("reset busy/flags", {12'd0, if0.out_busy, if0.out_overrun, if0.out_parity_err, if0.out_frame_err}, 16'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 8N1 0xA5 with pin-to-valid latency
        exp_q0.push_back('{9'h0A5, 1'b0, 1'b0});
        n = 0;
        fork
            send(0, {6'd0, 1'b1, 8'hA5, 1'b0}, 10, 16);
            begin
                while (n < 400 && !if0.out_valid) begin
                    @(posedge clk);
                    n++;
                    #1;
                end
                chk("latency 0xA5", 16'(n), 16'd156);
            end
        join
        repeat (10) @(posedge clk);
        #1;

        // 7E1: good parity, bad parity, another good one
        exp_q1.push_back('{9'h055, 1'b0, 1'b0});
        send(1, {6'd0, 1'b1, 1'b0, 7'h55, 1'b0}, 10, 16);
        exp_q1.push_back('{9'h055, 1'b1, 1'b0});
        send(1, {6'd0, 1'b1, 1'b1, 7'h55, 1'b0}, 10, 16);
        exp_q1.push_back('{9'h003, 1'b0, 1'b0});
        send(1, {6'd0, 1'b1, 1'b0, 7'h03, 1'b0}, 10, 16);

        // 8N2: second stop low, then a held break
        exp_q2.push_back('{9'h03C, 1'b0, 1'b1});
        send(2, {5'd0, 1'b0, 1'b1, 8'h3C, 1'b0}, 11, 16);
        repeat (40 * 16) @(posedge clk);
        #1;
        chk("break busy", {15'd0, if2.out_busy}, 16'd0);
        line2 = 1'b1;
        repeat (32) @(posedge clk);
        #1;
        exp_q2.push_back('{9'h0C3, 1'b0, 1'b0});
        send(2, {5'd0, 2'b11, 8'hC3, 1'b0}, 11, 16);
        repeat (10) @(posedge clk);
        #1;

        // Overrun: second frame dropped while first is unaccepted
        if0.in_ready = 1'b0;
        exp_q0.push_back('{9'h011, 1'b0, 1'b0});
        send(0, {6'd0, 1'b1, 8'h11, 1'b0}, 10, 16);
        send(0, {6'd0, 1'b1, 8'h22, 1'b0}, 10, 16);
        repeat (4) @(posedge clk);
        #1;
        chk("held valid", {15'd0, if0.out_valid}, 16'd1);
        chk("held data", {8'd0, if0.out_data}, 16'h0011);
        chk("overrun cycles", 16'(ovr_cycles0), 16'd1);
        if0.in_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("valid after accept", {15'd0, if0.out_valid}, 16'd0);

        // Start glitch
        line0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("glitch busy high", {15'd0, if0.out_busy}, 16'd1);
        line0 = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("glitch busy low", {15'd0, if0.out_busy}, 16'd0);
        chk("glitch no valid", {15'd0, if0.out_valid}, 16'd0);

        // Divisor change mid-frame
        exp_q0.push_back('{9'h081, 1'b0, 1'b0});
        fork
            send(0, {6'd0, 1'b1, 8'h81, 1'b0}, 10, 16);
            begin
                repeat (50) @(posedge clk);
                #1 div0 = 16'd32;
            end
        join
        exp_q0.push_back('{9'h03E, 1'b0, 1'b0});
        send(0, {6'd0, 1'b1, 8'h3E, 1'b0}, 10, 32);
        div0 = 16'd16;
        repeat (10) @(posedge clk);
        #1;

        // Asynchronous reset mid-DATA of 0xFF
        fork
            send(0, {6'd0, 1'b1, 8'hFF, 1'b0}, 10, 16);
            begin
                repeat (60) @(posedge clk);
                #3 rst_n = 1'b0;
                #1;
                chk("async rst busy", {15'd0, if0.out_busy}, 16'd0);
                chk("async rst data", {8'd0, if0.out_data}, 16'd0);
                chk("async rst valid/flags", {12'd0, if0.out_valid, if0.out_overrun, if0.out_parity_err, if0.out_frame_err}, 16'd0);
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
        join
        repeat (5) @(posedge clk);
        #1;
        exp_q0.push_back('{9'h042, 1'b0, 1'b0});
        send(0, {6'd0, 1'b1, 8'h42, 1'b0}, 10, 16);

        n = 0;
        while (n < 2000 && (exp_q0.size() + exp_q1.size() + exp_q2.size()) != 0) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("dut0 pending", 16'(exp_q0.size()), 16'd0);
        chk("dut1 pending", 16'(exp_q1.size()), 16'd0);
        chk("dut2 pending", 16'(exp_q2.size()), 16'd0);
        chk("total overrun cycles", 16'(ovr_cycles0), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
